// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing one L2 port between I-cache line fills and
// D-cache line fills / write-backs. One transaction at a time.
module l2_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;
  typedef enum logic {PTR_I, PTR_D} ptr_t;

  state_t state, state_nxt;
  ptr_t   ptr, ptr_nxt;
  logic   op_write, op_write_nxt;
  logic   d_req;

  assign d_req = d_read | d_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= PTR_D;
      op_write <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      op_write <= op_write_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    op_write_nxt = op_write;
    l2_read      = 1'b0;
    l2_write     = 1'b0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    l2_address   = i_address;
    unique case (state)
      IDLE: begin
        // Pointer names the last requester served; on contention the other one wins.
        if (i_read && (!d_req || ptr == PTR_D)) begin
          state_nxt    = SERVE_I;
          op_write_nxt = 1'b0;
        end else if (d_req) begin
          state_nxt    = SERVE_D;
          op_write_nxt = d_write;
        end
      end
      SERVE_I: begin
        l2_read  = ~op_write;
        l2_write = op_write;
        if (l2_resp) begin
          i_resp    = 1'b1;
          ptr_nxt   = PTR_I;
          state_nxt = RELEASE;
        end
      end
      SERVE_D: begin
        l2_address = d_address;
        l2_read    = ~op_write;
        l2_write   = op_write;
        if (l2_resp) begin
          d_resp    = 1'b1;
          ptr_nxt   = PTR_D;
          state_nxt = RELEASE;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign l2_wdata = d_wdata;
  assign i_rdata  = l2_rdata;
  assign d_rdata  = l2_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Testbench for l2_arbiter: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level model of the arbiter.
module tb_l2_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam logic [LINE_W-1:0] ONE  = 1;
  localparam logic [LINE_W-1:0] ZERO = 0;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_read, i_resp;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              d_read, d_write, d_resp;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata, d_rdata;
  logic              l2_read, l2_write, l2_resp;
  logic [ADDR_W-1:0] l2_address;
  logic [LINE_W-1:0] l2_wdata, l2_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
    .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp)
  );

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // L2 responder: answers a pending request after rsp_lat cycles (random when < 0);
  // spur_mode 1 = occasional, 2 = constant l2_resp pulses while no request is pending.
  int                rsp_lat   = -1;
  int                spur_mode = 0;
  bit                fix_en    = 0;
  logic [LINE_W-1:0] fix_data  = '0;

  initial begin
    int cnt, lat;
    cnt = 0; lat = 0;
    l2_resp = 1'b0; l2_rdata = '0;
    forever begin
      @(posedge clk); #1;
      l2_resp  = 1'b0;
      l2_rdata = fix_en ? fix_data : rand_line();
      if (rst) cnt = 0;
      else if (l2_read || l2_write) begin
        if (cnt == 0) lat = (rsp_lat < 0) ? int'($urandom_range(0, 4)) : rsp_lat;
        if (cnt == lat) begin l2_resp = 1'b1; cnt = 0; end
        else cnt++;
      end else begin
        cnt = 0;
        if (spur_mode == 2 || (spur_mode == 1 && $urandom_range(0, 5) == 0)) l2_resp = 1'b1;
      end
    end
  end

  // Reference model: owner of the L2 port (0 none, 1 I, 2 D), the op it was granted,
  // the requester served last, and a one-cycle cool-down after each completion.
  int owner = 0;
  int last  = 2;
  bit op_wr = 0;
  bit cool  = 0;
  bit i_got = 0;
  bit d_got = 0;

  initial begin
    bit serving, want_i, want_d;
    forever begin
      @(negedge clk);
      chk("i_rdata_pass", i_rdata, l2_rdata);
      chk("d_rdata_pass", d_rdata, l2_rdata);
      i_got = i_resp;
      d_got = d_resp;
      if (rst) begin
        chk("rst_l2_read", LINE_W'(l2_read), ZERO);
        chk("rst_l2_write", LINE_W'(l2_write), ZERO);
        chk("rst_i_resp", LINE_W'(i_resp), ZERO);
        chk("rst_d_resp", LINE_W'(d_resp), ZERO);
        owner = 0; last = 2; op_wr = 0; cool = 0;
      end else begin
        serving = (owner != 0);
        chk("m_l2_read", LINE_W'(l2_read), LINE_W'(serving && !op_wr));
        chk("m_l2_write", LINE_W'(l2_write), LINE_W'(serving && op_wr));
        chk("m_i_resp", LINE_W'(i_resp), LINE_W'(owner == 1 && l2_resp));
        chk("m_d_resp", LINE_W'(d_resp), LINE_W'(owner == 2 && l2_resp));
        if (serving)
          chk("m_l2_addr", LINE_W'(l2_address), LINE_W'(owner == 1 ? i_address : d_address));
        if (serving && op_wr) chk("m_l2_wdata", l2_wdata, d_wdata);
        if (owner != 0) begin
          if (l2_resp) begin last = owner; owner = 0; cool = 1; end
        end else if (cool) begin
          cool = 0;
        end else begin
          want_i = i_read;
          want_d = d_read | d_write;
          if (want_i && want_d) owner = (last == 2) ? 1 : 2;
          else if (want_i) owner = 1;
          else if (want_d) owner = 2;
          op_wr = (owner == 2) && d_write;
        end
      end
    end
  end

  task automatic wait_req(output int n);
    bit ok;
    n = 0; ok = 0;
    while (!ok && n < 64) begin
      @(negedge clk);
      n++;
      ok = l2_read | l2_write;
    end
    chk("req_seen", LINE_W'(ok), ONE);
  endtask

  task automatic wait_resp(input bit is_d, output bit ok);
    ok = is_d ? d_resp : i_resp;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      ok = is_d ? d_resp : i_resp;
    end
    chk(is_d ? "d_resp_seen" : "i_resp_seen", LINE_W'(ok), ONE);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drive_rand();
    if (i_read && i_got) i_read = 1'b0;
    else if (!i_read && $urandom_range(0, 2) == 0) begin
      i_read = 1'b1; i_address = $urandom;
    end
    if ((d_read || d_write) && d_got) begin
      d_read = 1'b0; d_write = 1'b0;
    end else if (!(d_read || d_write)) begin
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 1) d_write = 1'b1;
        else d_read = 1'b1;
        d_address = $urandom;
        d_wdata   = rand_line();
      end
    end else if (d_write) d_read = 1'($urandom_range(0, 1));
  endtask

  initial begin
    int n;
    bit ok;
    rst = 1'b1; i_read = 0; i_address = '0;
    d_read = 0; d_write = 0; d_address = '0; d_wdata = '0;
    repeat (3) @(posedge clk);

    // Solo I-fill with a 5-cycle L2 latency and a fixed pattern.
    rsp_lat = 5; fix_data = {32{8'hA5}}; fix_en = 1;
    #1 rst = 1'b0;
    i_address = 32'h0000_1040; i_read = 1;
    wait_req(n);
    chk("fill_latency", LINE_W'(n), LINE_W'(2));
    chk("fill_l2_read", LINE_W'(l2_read), ONE);
    chk("fill_addr", LINE_W'(l2_address), LINE_W'(32'h0000_1040));
    wait_resp(0, ok);
    chk("fill_rdata", i_rdata, fix_data);
    chk("fill_d_resp", LINE_W'(d_resp), ZERO);
    @(posedge clk); #1 i_read = 0; fix_en = 0; rsp_lat = -1;
    chk("fill_release", LINE_W'(l2_read), ZERO);

    // Both held continuously after reset: grants alternate I,D,I,D,I,D.
    do_reset();
    i_address = 32'h0000_1000; d_address = 32'h0000_2000; i_read = 1; d_read = 1;
    for (int k = 0; k < 6; k++) begin
      wait_req(n);
      chk("rr_gap", LINE_W'(n), (k == 0) ? LINE_W'(2) : LINE_W'(3));
      chk("rr_grant", LINE_W'(l2_address), LINE_W'((k % 2 == 0) ? i_address : d_address));
      wait_resp(k % 2 == 1, ok);
    end
    @(posedge clk); #1 i_read = 0; d_read = 0;

    // D write-back with d_read glitching while the transaction is open.
    d_write = 1; d_address = 32'h0000_2000; d_wdata = {8{32'h1234_5678}}; rsp_lat = 4;
    wait_req(n);
    ok = 0;
    for (int c = 0; c < 20 && !ok; c++) begin
      chk("wb_l2_write", LINE_W'(l2_write), ONE);
      chk("wb_l2_read", LINE_W'(l2_read), ZERO);
      chk("wb_wdata", l2_wdata, {8{32'h1234_5678}});
      ok = d_resp;
      if (!ok) begin @(posedge clk); #1 d_read = ~d_read; @(negedge clk); end
    end
    chk("wb_done", LINE_W'(ok), ONE);

    // Spurious l2_resp in RELEASE and IDLE must be ignored.
    spur_mode = 2;
    @(posedge clk); #1 d_write = 0; d_read = 0;
    repeat (4) begin
      @(negedge clk);
      chk("spur_i_resp", LINE_W'(i_resp), ZERO);
      chk("spur_d_resp", LINE_W'(d_resp), ZERO);
      chk("spur_l2_req", LINE_W'(l2_read | l2_write), ZERO);
    end
    spur_mode = 0; rsp_lat = 1;
    @(posedge clk); #1 i_read = 1; i_address = 32'h0000_0040;
    wait_req(n);
    chk("spur_after_latency", LINE_W'(n), LINE_W'(2));
    wait_resp(0, ok);
    @(posedge clk); #1 i_read = 0;

    // Asynchronous reset in the middle of a D write, then re-grant of held d_read.
    rsp_lat = 10; d_address = 32'h0000_3000; d_write = 1; d_read = 1;
    wait_req(n);
    chk("ar_l2_write_before", LINE_W'(l2_write), ONE);
    @(negedge clk); #2 rst = 1'b1; #1;
    chk("ar_l2_write_async", LINE_W'(l2_write), ZERO);
    chk("ar_l2_read_async", LINE_W'(l2_read), ZERO);
    chk("ar_d_resp_async", LINE_W'(d_resp), ZERO);
    rsp_lat = 2; d_write = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("ar_regrant_read", LINE_W'(l2_read), ONE);
    chk("ar_regrant_write", LINE_W'(l2_write), ZERO);
    chk("ar_regrant_addr", LINE_W'(l2_address), LINE_W'(32'h0000_3000));
    @(negedge clk);
    wait_resp(1, ok);
    @(posedge clk); #1 d_read = 0;

    // Randomized traffic with spurious responses, checked by the model.
    spur_mode = 1; rsp_lat = -1;
    repeat (1500) begin
      @(posedge clk); #1;
      drive_rand();
    end
    repeat (20) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
